// File: rtl/ibex_fetch_realign_buffer.sv
// Fetch word FIFO that realigns 32-bit memory words on 16-bit boundaries and
// presents one compressed or full-width instruction per cycle with its PC and error flags.
module ibex_fetch_realign_buffer #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        busy_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_rdata_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] BUSY_LVL = CNT_W'(DEPTH - 1);

  logic [31:0]      r_mem [DEPTH];
  logic [DEPTH-1:0] r_err;
  logic [CNT_W-1:0] r_count;
  logic             r_off;
  logic [31:0]      r_pc;

  logic [31:0]      w_mem_n [DEPTH];
  logic [DEPTH-1:0] w_err_n;
  logic [CNT_W-1:0] w_count_n;
  logic             w_off_n;
  logic [31:0]      w_pc_n;

  logic             w_v0, w_v1, w_comp, w_short;
  logic [1:0]       w_half;
  logic             w_valid, w_err, w_plus2;
  logic [31:0]      w_rdata, w_chk_data;
  logic             w_acc, w_pop, w_push;
  logic [CNT_W-1:0] w_wr_idx;
  logic             w_unused_addr;

  assign w_unused_addr = addr_i[0];

  assign w_v0    = (r_count != '0);
  assign w_v1    = (r_count >= CNT_W'(2));
  assign w_half  = r_off ? r_mem[0][17:16] : r_mem[0][1:0];
  assign w_comp  = (w_half != 2'b11);
  // Unaligned full-width instruction released early because its first half already faulted
  assign w_short = r_off & ~w_comp & ~w_v1 & w_v0 & r_err[0];

  always_comb begin
    w_valid = 1'b0;
    w_rdata = r_mem[0];
    w_err   = r_err[0];
    w_plus2 = 1'b0;
    if (!r_off) begin
      w_valid = w_v0;
    end else begin
      w_rdata = {r_mem[1][15:0], r_mem[0][31:16]};
      if (w_comp) begin
        w_valid = w_v0;
      end else begin
        w_valid = w_v1 | (w_v0 & r_err[0]);
        w_err   = r_err[0] | (w_v1 & r_err[1]);
        w_plus2 = w_v1 & ~r_err[0] & r_err[1];
      end
    end
  end

  assign w_acc    = w_valid & out_ready_i;
  assign w_pop    = w_acc & (r_off | ~w_comp);
  assign w_push   = in_valid_i & ((r_count != FULL_LVL) | w_pop);
  assign w_wr_idx = r_count - CNT_W'(w_pop);

  // Next state: clear wins, otherwise shift on pop then write behind the tail
  always_comb begin
    w_mem_n   = r_mem;
    w_err_n   = r_err;
    w_count_n = r_count;
    w_off_n   = r_off;
    w_pc_n    = r_pc;
    if (clear_i) begin
      w_count_n = '0;
      w_off_n   = addr_i[1];
      w_pc_n    = {addr_i[31:1], 1'b0};
    end else begin
      if (w_pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          w_mem_n[i] = r_mem[i+1];
          w_err_n[i] = r_err[i+1];
        end
      end
      if (w_push) begin
        w_mem_n[w_wr_idx[IDX_W-1:0]] = in_rdata_i;
        w_err_n[w_wr_idx[IDX_W-1:0]] = in_err_i;
      end
      w_count_n = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_acc) begin
        w_pc_n  = r_pc + (w_comp ? 32'd2 : 32'd4);
        w_off_n = r_off ? (~w_comp & w_v1) : w_comp;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_err   <= '0;
      r_count <= '0;
      r_off   <= 1'b0;
      r_pc    <= '0;
    end else begin
      r_mem   <= w_mem_n;
      r_err   <= w_err_n;
      r_count <= w_count_n;
      r_off   <= w_off_n;
      r_pc    <= w_pc_n;
    end
  end

  assign busy_o          = (r_count >= BUSY_LVL);
  assign out_valid_o     = w_valid;
  assign out_addr_o      = r_pc;
  assign out_rdata_o     = w_rdata;
  assign out_err_o       = w_err;
  assign out_err_plus2_o = w_plus2;

  // Only the halfwords that belong to the presented instruction must hold steady
  assign w_chk_data = (w_comp | w_short) ? {16'h0000, w_rdata[15:0]} : w_rdata;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(in_valid_i && !clear_i && (r_count == FULL_LVL) && !w_pop));

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_o && !out_ready_i && !clear_i) |=>
      (out_valid_o && $stable(out_addr_o) && $stable(w_chk_data)));

  a_known_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_v0 |-> !$isunknown({r_mem[0][17:16], r_mem[0][1:0]}));

endmodule

// File: doc/ibex_fetch_realign_buffer.md
# ibex_fetch_realign_buffer

Fetch-side word FIFO that sits directly upstream of the compressed instruction decoder. It stores 32-bit instruction-memory words from the prefetch logic and re-aligns them on 16-bit boundaries. Each cycle it presents one candidate instruction (compressed or full-width, aligned or straddling two words) with its PC and error flags. The buffer is flushed on every branch/jump and restarts at the new target address.

## Interface
- DEPTH, 3: FIFO capacity in 32-bit words; legal range is 2–8.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  flush all entries and restart at addr_i.
- addr_i  in  32  new fetch PC, sampled when clear_i=1; bit 0 ignored.
- in_valid_i  in  1  a fetched word is presented this cycle.
- in_rdata_i  in  32  fetched word (word-aligned).
- in_err_i  in  1  bus error on the fetched word.
- busy_o  out  1  occupancy >= DEPTH-1; upstream must stop issuing requests.
- out_valid_o  out  1  instruction at out_addr_o is available.
- out_ready_i  in  1  consumer accepts the instruction this cycle.
- out_addr_o  out  32  PC of the presented instruction; bit 0 always 0.
- out_rdata_o  out  32  instruction bits. For a compressed instruction, only [15:0] are meaningful.
- out_err_o  out  1  instruction is affected by a fetch error.
- out_err_plus2_o  out  1  error lies only in the upper halfword (second word) of an unaligned 32-bit instruction.

## Operation
- State:
  - word array with per-entry err bit;
  - occupancy count 0..DEPTH;
  - halfword offset bit `off`;
  - PC register.
- Words are consumed oldest-first. Entry 0 is the head (w0) and entry 1 is the next word (w1).
- Compressed test: the low 2 bits of the selected halfword are != 2'b11.
- Aligned presentation (off=0):
  - out_rdata_o = w0;
  - out_valid_o = entry 0 valid;
  - out_err_o = err0.
- Unaligned presentation (off=1):
  - out_rdata_o = {w1[15:0], w0[31:16]}.
  - Compressed: valid = entry 0 valid; out_err_o = err0.
  - Uncompressed: valid = entries 0 and 1 valid, or entry 0 valid with err0=1 (error short-circuit).
  - Uncompressed: out_err_o = err0 | err1; out_err_plus2_o = ~err0 & err1 (requires both entries valid).
- out_err_plus2_o is 0 in every other case.
- On acceptance (out_valid_o & out_ready_i):
  - off=0, compressed: off←1, no pop, PC+=2.
  - off=0, uncompressed: pop 1 word, PC+=4.
  - off=1, compressed: pop 1 word, off←0, PC+=2.
  - off=1, uncompressed: pop 1 word, off stays 1, PC+=4.
  - off=1, uncompressed, accepted under the error short-circuit (entry 1 invalid): pop 1 word, off←0.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFE + 2 wraps to 0x0000_0000.
- Push: when in_valid_i=1, the word is written behind the current tail. Push and pop may occur in the same cycle; occupancy is then unchanged.
- Protocol error: in_valid_i=1 while occupancy==DEPTH and no pop in the same cycle. An assertion covers this case. RTL behaviour is don't-care, but the pointers must stay in range.
- Clear takes priority over everything else in the same cycle:
  - occupancy←0;
  - off←addr_i[1];
  - PC←{addr_i[31:1],1'b0};
  - any push or accept in that cycle is discarded.
- Assertions:
  - out_valid_o, once asserted, holds with stable data until accepted or cleared;
  - no X on in_rdata_i[1:0] / in_rdata_i[17:16] when the respective entry is valid.

## Timing
- Reset values:
  - occupancy 0, off 0, PC 0;
  - out_valid_o=0, busy_o=0, out_err_o=0, out_err_plus2_o=0;
  - out_addr_o=0, out_rdata_o=0 (entries zeroed).
- Latency: a word pushed in cycle N is presentable in cycle N+1. There is no combinational in→out bypass.
- All outputs are functions of registered state only, except that busy_o is registered occupancy-based.
- out_ready_i may depend combinationally on out_* signals. No out_* output depends on out_ready_i.
- Throughput: one instruction per cycle when entries are available.
- After clear in cycle N, out_valid_o=0 in N+1 unless a word was pushed in N+1-1. Any such push is discarded, so the earliest valid output is N+2.
- An asynchronous reset mid-operation drops all entries immediately.

## Test plan
- Aligned stream:
  - Stimulus: clear to 0x80, push 0x0000_0013 and 0x0010_0093.
  - Required: outputs at 0x80 then 0x84 with those exact data, one per cycle; out_valid_o=0 afterwards.
- Compressed pair:
  - Stimulus: push 0x4505_4501.
  - Required: 0x80 presents [15:0]=0x4501, 0x82 presents [15:0]=0x4505; pop only after the second acceptance.
- Straddling:
  - Stimulus: clear to 0x82, push 0x0013_xxxx; out_valid_o=0 with 1 entry. Then push 0xxxxx_0000.
  - Required: out_rdata_o=0x0000_0013 at 0x82 (the 32-bit instruction formed from w0[31:16]=0x0013 and w1[15:0]=0x0000); next PC 0x86.
- Error split:
  - Stimulus: unaligned uncompressed instruction with err0=0, err1=1.
  - Required: out_err_o=1, out_err_plus2_o=1. With err0=1 and only 1 entry: out_valid_o=1, out_err_plus2_o=0.
- Flush race:
  - Stimulus: FIFO full (busy_o=1), clear_i and in_valid_i in the same cycle with addr 0x100.
  - Required: next cycle occupancy 0, busy_o=0, out_valid_o=0, out_addr_o=0x100.
- Wrap and backpressure:
  - Stimulus: PC 0xFFFF_FFFC holding a 32-bit instruction, out_ready_i=0 for 3 cycles.
  - Required: output stable during the stall; after acceptance out_addr_o=0x0000_0000.
